// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-ported RAM between instruction-fetch and data requesters
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   iREN, iaddr               instruction read request and word address
//   iwait, iload              low for the completing cycle of a fetch; fetched word (0 while iwait high)
//   dREN, dWEN, daddr, dstore data read/write request (write wins), address, write data
//   dwait, dload              low for the completing cycle of a data access; read word (0 while dwait high)
//   ramREN, ramWEN, ramaddr,
//   ramstore                  RAM request side
//   ramload, ramstate         RAM read data and status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//   arb_err                   one-cycle pulse when a grant is aborted by ERROR (or timeout)
//
// Optional feature: define ARB_TIMEOUT_EN to abort grants that see no ACCESS
// within TIMEOUT cycles. Without it a grant waits indefinitely.
module ram_port_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer_q, timer_d;

  assign timeout = (timer_q == TW'(TIMEOUT - 1));

  // Counts consecutive cycles spent in one grant; any state change restarts it.
  always_comb begin
    timer_d = '0;
    if (state_d == state_q && state_q != IDLE) begin
      timer_d = timer_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    arb_err  = 1'b0;

    case (state_q)
      IDLE: begin
        // The streak only matters while a fetch is actually waiting.
        if (!iREN) begin
          streak_d = '0;
        end
        if (dREN || dWEN) begin
          state_d = (streak_q == STREAK_TOP && iREN) ? IGNT : DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end

      IGNT: begin
        // Enable follows the request so a dropped fetch releases the RAM at once.
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait    = 1'b0;
          iload    = ramload;
          streak_d = '0;
          state_d  = IDLE;
        end else if (ramstate == RAM_ERROR || timeout) begin
          arb_err = 1'b1;
          state_d = IDLE;
        end
      end

      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
          if (iREN && streak_q != STREAK_TOP) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (ramstate == RAM_ERROR || timeout) begin
          arb_err = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
`ifdef ARB_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
`ifdef ARB_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        arb_err;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  ram_port_arbiter #(.STREAK_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int dcnt;
    logic got_i;

    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    // Reset held two cycles with a fetch pending
    tick(); tick();
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_arb_err", arb_err, 0);
    check("rst_iload", iload, 0);

    nRST = 1'b1;
    tick();
    check("rel_ramREN", ramREN, 1);
    check("rel_ramaddr", ramaddr, 32'h40);
    check("rel_iwait_free", iwait, 1);
    ramstate = ACCESS; ramload = 32'h1111; #1;
    check("rel_iwait_acc", iwait, 0);
    check("rel_iload", iload, 32'h1111);
    tick();
    iREN = 1'b0; ramstate = FREE; #1;
    check("post_i_idle_ramREN", ramREN, 0);
    check("post_i_idle_iwait", iwait, 1);

    // Simultaneous request: data side first
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
    tick();
    check("sim_d_ramREN", ramREN, 1);
    check("sim_d_ramaddr", ramaddr, 32'h100);
    check("sim_d_busy_dwait", dwait, 1);
    tick();
    check("sim_d_busy2_dwait", dwait, 1);
    tick();
    ramstate = ACCESS; ramload = 32'hABCD; #1;
    check("sim_d_dwait", dwait, 0);
    check("sim_d_dload", dload, 32'hABCD);
    check("sim_d_iwait", iwait, 1);
    tick();
    dREN = 1'b0; ramstate = FREE; #1;
    check("sim_idle_ramREN", ramREN, 0);
    check("sim_idle_dwait", dwait, 1);
    tick();
    check("sim_i_ramREN", ramREN, 1);
    check("sim_i_ramaddr", ramaddr, 32'h44);
    ramstate = ACCESS; ramload = 32'h5555; #1;
    check("sim_i_iwait", iwait, 0);
    check("sim_i_iload", iload, 32'h5555);
    tick();
    iREN = 1'b0; ramstate = FREE;

    // Starvation: continuous writes against a pending fetch
    iREN = 1'b1; iaddr = 32'h48; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12;
    ramstate = ACCESS;
    dcnt = 0; got_i = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!dwait) dcnt++;
      if (!iwait) begin
        got_i = 1'b1;
        break;
      end
    end
    check("starve_i_done", got_i, 1);
    check("starve_d_count", dcnt, 4);
    tick();
    check("starve_streak_clr", dut.streak_q, 0);
    iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;

    // Write priority
    dREN = 1'b1; dWEN = 1'b1; dstore = 32'hDEADBEEF; daddr = 32'h300; ramstate = BUSY;
    tick();
    check("wp_ramWEN", ramWEN, 1);
    check("wp_ramREN", ramREN, 0);
    check("wp_ramstore", ramstore, 32'hDEADBEEF);
    check("wp_ramaddr", ramaddr, 32'h300);
    dWEN = 1'b0; #1;
    check("wp_read_ramREN", ramREN, 1);
    check("wp_read_ramWEN", ramWEN, 0);

    // Drop mid-grant: enables fall at once, no wait pulse even if ACCESS arrives
    dREN = 1'b0; ramstate = ACCESS; #1;
    check("drop_ramREN", ramREN, 0);
    check("drop_ramWEN", ramWEN, 0);
    check("drop_dwait", dwait, 1);
    tick();
    ramstate = FREE; #1;
    check("drop_idle_dwait", dwait, 1);
    check("drop_idle_ramREN", ramREN, 0);

    // ERROR abort then retry
    dREN = 1'b1; daddr = 32'h10;
    tick();
    ramstate = ERROR; #1;
    check("err_arb_err", arb_err, 1);
    check("err_dwait", dwait, 1);
    check("err_dload", dload, 0);
    tick();
    ramstate = FREE; #1;
    check("err_pulse_end", arb_err, 0);
    check("err_idle_ramREN", ramREN, 0);
    tick();
    check("retry_ramREN", ramREN, 1);
    check("retry_ramaddr", ramaddr, 32'h10);
    ramstate = ACCESS; ramload = 32'h77; #1;
    check("retry_dwait", dwait, 0);
    check("retry_dload", dload, 32'h77);
    tick();
    dREN = 1'b0; ramstate = FREE;

    // Reset asserted mid-grant
    iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    tick();
    check("rstmid_grant_ramREN", ramREN, 1);
    nRST = 1'b0;
    tick();
    ramstate = ACCESS; #1;
    check("rstmid_ramREN", ramREN, 0);
    check("rstmid_iwait", iwait, 1);
    ramstate = FREE; iREN = 1'b0; nRST = 1'b1;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Grant stuck BUSY aborts on its 8th cycle
    iREN = 1'b1; ramstate = BUSY;
    tick();
    for (int c = 1; c < 8; c++) begin
      check($sformatf("to_quiet_%0d", c), arb_err, 0);
      tick();
    end
    check("to_arb_err", arb_err, 1);
    check("to_iwait", iwait, 1);
    tick();
    check("to_idle_ramREN", ramREN, 0);
    iREN = 1'b0; ramstate = FREE;
    tick();
`else
    // Without the timer a stuck grant simply persists
    iREN = 1'b1; ramstate = BUSY;
    tick();
    repeat (80) tick();
    check("nto_ramREN", ramREN, 1);
    check("nto_arb_err", arb_err, 0);
    check("nto_iwait", iwait, 1);
    iREN = 1'b0; ramstate = FREE;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
